// File: rtl/frame_readout_controller.sv
// Frame readout controller: snapshots four measurement registers plus an XOR
// checksum on Capture, then hands the five bytes to an MCU one at a time over
// a four-phase ReadNextByte/ByteReady handshake.
module frame_readout_controller #(
  parameter int BUS_WIDTH         = 8,
  parameter int REGISTER_QUANTITY = 4   // only 4 is supported
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic [BUS_WIDTH-1:0] Register0,
  input  logic [BUS_WIDTH-1:0] Register1,
  input  logic [BUS_WIDTH-1:0] Register2,
  input  logic [BUS_WIDTH-1:0] Register3,
  input  logic                 Enable,
  input  logic                 Capture,
  input  logic                 ReadNextByte,
  output logic [BUS_WIDTH-1:0] McuBus,
  output logic                 ByteReady,
  output logic                 FrameReady,
  output logic                 FrameDone,
  output logic                 Overrun,
  output logic [2:0]           ByteIndex
);

  typedef enum logic [1:0] {IDLE, ARMED, HANDSHAKE} state_e;

  // Index of the checksum byte, which follows the data bytes.
  localparam logic [2:0] LAST_IDX = 3'(REGISTER_QUANTITY);

  state_e                                     state_q;
  logic [REGISTER_QUANTITY-1:0][BUS_WIDTH-1:0] shadow_q;
  logic [BUS_WIDTH-1:0]                       csum_q;
  logic [BUS_WIDTH-1:0]                       bus_q;
  logic                                       byte_rdy_q;
  logic                                       frame_rdy_q;
  logic                                       frame_done_q;
  logic                                       overrun_q;
  logic [2:0]                                 idx_q;

  logic [BUS_WIDTH-1:0]                       csum_d;
  logic [BUS_WIDTH-1:0]                       byte_sel_d;

  // Checksum of the live registers and the frame byte at the current index.
  always_comb begin
    csum_d     = Register0 ^ Register1 ^ Register2 ^ Register3;
    byte_sel_d = (idx_q == LAST_IDX) ? csum_q : shadow_q[idx_q[1:0]];
  end

  // Capture / readout state machine; every output is registered here.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q      <= IDLE;
      shadow_q     <= '0;
      csum_q       <= '0;
      bus_q        <= '0;
      byte_rdy_q   <= 1'b0;
      frame_rdy_q  <= 1'b0;
      frame_done_q <= 1'b0;
      overrun_q    <= 1'b0;
      idx_q        <= '0;
    end else begin
      frame_done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          // ReadNextByte is ignored here; Capture only counts when enabled.
          if (Capture && Enable) begin
            shadow_q    <= {Register3, Register2, Register1, Register0};
            csum_q      <= csum_d;
            idx_q       <= '0;
            frame_rdy_q <= 1'b1;
            overrun_q   <= 1'b0;
            state_q     <= ARMED;
          end
        end
        ARMED: begin
          if (Capture) overrun_q <= 1'b1;
          if (ReadNextByte) begin
            bus_q      <= byte_sel_d;
            byte_rdy_q <= 1'b1;
            state_q    <= HANDSHAKE;
          end
        end
        HANDSHAKE: begin
          // A Capture on the final release edge still lands while busy.
          if (Capture) overrun_q <= 1'b1;
          if (!ReadNextByte) begin
            byte_rdy_q <= 1'b0;
            if (idx_q == LAST_IDX) begin
              idx_q        <= '0;
              frame_rdy_q  <= 1'b0;
              frame_done_q <= 1'b1;
              state_q      <= IDLE;
            end else begin
              idx_q   <= idx_q + 3'd1;
              state_q <= ARMED;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign McuBus     = bus_q;
  assign ByteReady  = byte_rdy_q;
  assign FrameReady = frame_rdy_q;
  assign FrameDone  = frame_done_q;
  assign Overrun    = overrun_q;
  assign ByteIndex  = idx_q;

endmodule

// File: tb/tb_frame_readout_controller.sv
// Bench for frame_readout_controller: directed scenarios plus randomized frames
// checked against a transaction-level model (frame bytes + overrun flag).
module tb_frame_readout_controller;

  logic       Clk = 1'b0;
  logic       Reset = 1'b1;
  logic [7:0] Register0 = '0, Register1 = '0, Register2 = '0, Register3 = '0;
  logic       Enable = 1'b0, Capture = 1'b0, ReadNextByte = 1'b0;
  logic [7:0] McuBus;
  logic       ByteReady, FrameReady, FrameDone, Overrun;
  logic [2:0] ByteIndex;

  frame_readout_controller #(.BUS_WIDTH(8), .REGISTER_QUANTITY(4)) dut (
    .Clk(Clk), .Reset(Reset),
    .Register0(Register0), .Register1(Register1),
    .Register2(Register2), .Register3(Register3),
    .Enable(Enable), .Capture(Capture), .ReadNextByte(ReadNextByte),
    .McuBus(McuBus), .ByteReady(ByteReady), .FrameReady(FrameReady),
    .FrameDone(FrameDone), .Overrun(Overrun), .ByteIndex(ByteIndex)
  );

  always #5 Clk = ~Clk;

  int n_chk = 0;
  int n_err = 0;

  // Reference model: the captured frame, the last byte put on the bus and
  // the sticky overrun flag.
  logic [7:0] frm [5];
  logic [7:0] last_bus = '0;
  logic       ov_m = 1'b0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge Clk);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_bus"},  32'(McuBus), 32'h0);
    chk({tag, "_brdy"}, 32'(ByteReady), 32'h0);
    chk({tag, "_frdy"}, 32'(FrameReady), 32'h0);
    chk({tag, "_done"}, 32'(FrameDone), 32'h0);
    chk({tag, "_ovr"},  32'(Overrun), 32'h0);
    chk({tag, "_idx"},  32'(ByteIndex), 32'h0);
  endtask

  task automatic do_capture(input logic [7:0] r0, input logic [7:0] r1,
                            input logic [7:0] r2, input logic [7:0] r3);
    Register0 = r0; Register1 = r1; Register2 = r2; Register3 = r3;
    Enable = 1'b1; Capture = 1'b1;
    tick;
    Capture = 1'b0;
    frm[0] = r0; frm[1] = r1; frm[2] = r2; frm[3] = r3;
    frm[4] = r0 ^ r1 ^ r2 ^ r3;
    ov_m = 1'b0;
    chk("cap_frdy", 32'(FrameReady), 32'h1);
    chk("cap_idx",  32'(ByteIndex), 32'h0);
    chk("cap_ovr",  32'(Overrun), 32'h0);
    chk("cap_brdy", 32'(ByteReady), 32'h0);
  endtask

  // Drive Capture with the given probability while a frame is busy.
  task automatic maybe_cap(input int cap_pct, input bit rnd_en);
    Capture = ($urandom_range(99) < cap_pct);
    if (Capture) ov_m = 1'b1;
    if (rnd_en) Enable = 1'($urandom);
  endtask

  // One full handshake for byte i: gap idle cycles, request, hold, release.
  task automatic read_byte(input int i, input int hold, input int gap,
                           input int cap_pct, input bit rnd_en);
    for (int g = 0; g < gap; g++) begin
      maybe_cap(cap_pct, rnd_en);
      tick;
      chk("gap_brdy", 32'(ByteReady), 32'h0);
      chk("gap_bus",  32'(McuBus), 32'(last_bus));
      chk("gap_idx",  32'(ByteIndex), 32'(i));
      chk("gap_ovr",  32'(Overrun), 32'(ov_m));
    end
    Capture = 1'b0;
    ReadNextByte = 1'b1;
    tick;
    chk("req_brdy", 32'(ByteReady), 32'h1);
    chk("req_bus",  32'(McuBus), 32'(frm[i]));
    chk("req_idx",  32'(ByteIndex), 32'(i));
    last_bus = frm[i];
    for (int h = 1; h < hold; h++) begin
      maybe_cap(cap_pct, rnd_en);
      tick;
      chk("hold_brdy", 32'(ByteReady), 32'h1);
      chk("hold_bus",  32'(McuBus), 32'(frm[i]));
      chk("hold_idx",  32'(ByteIndex), 32'(i));
      chk("hold_ovr",  32'(Overrun), 32'(ov_m));
    end
    ReadNextByte = 1'b0;
    maybe_cap(cap_pct, rnd_en);
    tick;
    Capture = 1'b0;
    chk("rel_brdy", 32'(ByteReady), 32'h0);
    chk("rel_bus",  32'(McuBus), 32'(last_bus));
    chk("rel_ovr",  32'(Overrun), 32'(ov_m));
    if (i == 4) begin
      chk("rel_done", 32'(FrameDone), 32'h1);
      chk("rel_frdy", 32'(FrameReady), 32'h0);
      chk("rel_idx",  32'(ByteIndex), 32'h0);
      tick;
      chk("done_pulse", 32'(FrameDone), 32'h0);
      chk("done_ovr",   32'(Overrun), 32'(ov_m));
    end else begin
      chk("rel_done", 32'(FrameDone), 32'h0);
      chk("rel_frdy", 32'(FrameReady), 32'h1);
      chk("rel_idx",  32'(ByteIndex), 32'(i + 1));
    end
  endtask

  // Attempts that must not start a frame while idle.
  task automatic idle_noise;
    Enable = 1'b0; Capture = 1'b1;
    tick;
    Capture = 1'b0;
    chk("dis_frdy", 32'(FrameReady), 32'h0);
    chk("dis_ovr",  32'(Overrun), 32'(ov_m));
    ReadNextByte = 1'b1;
    tick;
    chk("idle_brdy", 32'(ByteReady), 32'h0);
    chk("idle_bus",  32'(McuBus), 32'(last_bus));
    ReadNextByte = 1'b0;
    tick;
    chk("idle_brdy2", 32'(ByteReady), 32'h0);
  endtask

  initial begin
    // Reset, with a Capture held to show it is overridden.
    Enable = 1'b1; Capture = 1'b1;
    Register0 = 8'h5A;
    tick; tick;
    chk_all_zero("rst");
    Reset = 1'b0; Capture = 1'b0;
    tick;
    chk_all_zero("post_rst");

    // Basic frame; Register0 changes after capture and must not leak in.
    do_capture(8'h11, 8'h22, 8'h44, 8'h88);
    Register0 = 8'hAA;
    for (int i = 0; i < 5; i++) read_byte(i, 1, 0, 0, 1'b0);
    chk("basic_csum", 32'(last_bus), 32'hFF);

    // Disabled capture and idle requests.
    idle_noise();

    // Capture pulses during byte 2 set Overrun; frame completes intact.
    do_capture(8'h31, 8'h42, 8'h53, 8'h64);
    read_byte(0, 1, 0, 0, 1'b0);
    read_byte(1, 1, 0, 0, 1'b0);
    read_byte(2, 2, 1, 100, 1'b0);
    chk("ovr_set", 32'(Overrun), 32'h1);
    read_byte(3, 1, 0, 0, 1'b0);
    read_byte(4, 1, 0, 0, 1'b0);
    chk("ovr_sticky", 32'(Overrun), 32'h1);
    do_capture(8'h01, 8'h02, 8'h03, 8'h04);   // clears Overrun

    // Long hold on byte 0, then finish the frame.
    read_byte(0, 10, 0, 0, 1'b0);
    for (int i = 1; i < 5; i++) read_byte(i, 1, 1, 0, 1'b0);

    // Reset during the handshake of byte 3 with a simultaneous Capture.
    do_capture(8'hC3, 8'h3C, 8'h96, 8'h69);
    for (int i = 0; i < 3; i++) read_byte(i, 1, 0, 0, 1'b0);
    ReadNextByte = 1'b1;
    tick;
    chk("mid_brdy", 32'(ByteReady), 32'h1);
    Reset = 1'b1; Capture = 1'b1;
    tick;
    chk_all_zero("mid_rst");
    Reset = 1'b0; Capture = 1'b0; ReadNextByte = 1'b0;
    last_bus = '0; ov_m = 1'b0;
    tick;
    chk_all_zero("mid_rst2");
    do_capture(8'h10, 8'h20, 8'h30, 8'h40);
    for (int i = 0; i < 5; i++) read_byte(i, 1, 0, 0, 1'b0);

    // Randomized frames: random data, holds, gaps, stray Captures, Enable.
    for (int f = 0; f < 40; f++) begin
      if ($urandom_range(3) == 0) idle_noise();
      do_capture(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
      Register0 = 8'($urandom); Register3 = 8'($urandom);
      for (int i = 0; i < 5; i++)
        read_byte(i, $urandom_range(1, 4), $urandom_range(0, 2), 15, 1'b1);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
